// File: rtl/lsu_mem_sequencer.sv
// Load/store sequencer in front of a single-port synchronous data memory.
// Sub-word stores become read-modify-write; loads are lane-extracted and extended.
module lsu_mem_sequencer #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned MEM_AW = 10
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic              i_req_we,
   input  logic [1:0]        i_req_bhw,
   input  logic              i_req_sign,
   input  logic [WIDTH-1:0]  i_req_addr,
   input  logic [WIDTH-1:0]  i_req_wdata,
   output logic              o_resp_valid,
   output logic [WIDTH-1:0]  o_resp_rdata,
   output logic              o_resp_err,
   output logic              o_mem_re,
   output logic              o_mem_we,
   output logic [MEM_AW-1:0] o_mem_addr,
   output logic [WIDTH-1:0]  o_mem_wdata,
   input  logic [WIDTH-1:0]  i_mem_rdata
);

   typedef enum logic [2:0] {
      StIdle,
      StRd,
      StMrg,
      StWr,
      StResp
   } state_e;

   localparam int unsigned AddrKeep = MEM_AW + 2;

   state_e                r_state;
   state_e                w_state_nxt;

   logic                  r_we;
   logic [1:0]            r_bhw;
   logic                  r_sign;
   logic [AddrKeep-1:0]   r_addr;
   logic [WIDTH-1:0]      r_wdata;
   logic [WIDTH-1:0]      r_wbuf;
   logic                  r_resp_valid;
   logic [WIDTH-1:0]      r_resp_rdata;
   logic                  r_resp_err;

   logic                  w_we_nxt;
   logic [1:0]            w_bhw_nxt;
   logic                  w_sign_nxt;
   logic [AddrKeep-1:0]   w_addr_nxt;
   logic [WIDTH-1:0]      w_wdata_nxt;
   logic [WIDTH-1:0]      w_wbuf_nxt;
   logic                  w_resp_valid_nxt;
   logic [WIDTH-1:0]      w_resp_rdata_nxt;
   logic                  w_resp_err_nxt;

   logic                  w_accept;
   logic                  w_misalign;
   logic [7:0]            w_rd_byte;
   logic [15:0]           w_rd_half;
   logic [WIDTH-1:0]      w_load_data;
   logic [WIDTH-1:0]      w_merged;
   logic                  w_unused_addr;

   // Upper address bits are beyond the memory's reach and are dropped.
   assign w_unused_addr = ^i_req_addr[WIDTH-1:AddrKeep];

   assign w_accept   = i_req_valid && (r_state == StIdle);
   assign w_misalign = ((i_req_bhw == 2'd1) && i_req_addr[0]) ||
                       (i_req_bhw[1] && (i_req_addr[1:0] != 2'b00));

   // Load lane extraction from the word returned by memory.
   always_comb begin
      w_rd_byte = 8'h00;
      unique case (r_addr[1:0])
         2'd0: w_rd_byte = i_mem_rdata[7:0];
         2'd1: w_rd_byte = i_mem_rdata[15:8];
         2'd2: w_rd_byte = i_mem_rdata[23:16];
         2'd3: w_rd_byte = i_mem_rdata[31:24];
         default: w_rd_byte = 8'h00;
      endcase
      w_rd_half = r_addr[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];

      w_load_data = i_mem_rdata;
      case (r_bhw)
         2'd0: w_load_data = {{(WIDTH-8){r_sign & w_rd_byte[7]}}, w_rd_byte};
         2'd1: w_load_data = {{(WIDTH-16){r_sign & w_rd_half[15]}}, w_rd_half};
         default: w_load_data = i_mem_rdata;
      endcase
   end

   // Store merge: replace only the addressed lane of the fetched word.
   always_comb begin
      w_merged = i_mem_rdata;
      case (r_bhw)
         2'd0: begin
            unique case (r_addr[1:0])
               2'd0: w_merged[7:0]   = r_wdata[7:0];
               2'd1: w_merged[15:8]  = r_wdata[7:0];
               2'd2: w_merged[23:16] = r_wdata[7:0];
               2'd3: w_merged[31:24] = r_wdata[7:0];
               default: w_merged = i_mem_rdata;
            endcase
         end
         2'd1: begin
            if (r_addr[1]) begin
               w_merged[31:16] = r_wdata[15:0];
            end else begin
               w_merged[15:0] = r_wdata[15:0];
            end
         end
         default: w_merged = r_wdata;
      endcase
   end

   // Next-state and registered-response logic.
   always_comb begin
      w_state_nxt      = r_state;
      w_we_nxt         = r_we;
      w_bhw_nxt        = r_bhw;
      w_sign_nxt       = r_sign;
      w_addr_nxt       = r_addr;
      w_wdata_nxt      = r_wdata;
      w_wbuf_nxt       = r_wbuf;
      w_resp_valid_nxt = 1'b0;
      w_resp_rdata_nxt = r_resp_rdata;
      w_resp_err_nxt   = r_resp_err;

      case (r_state)
         StIdle: begin
            if (w_accept) begin
               w_we_nxt         = i_req_we;
               w_bhw_nxt        = i_req_bhw;
               w_sign_nxt       = i_req_sign;
               w_addr_nxt       = i_req_addr[AddrKeep-1:0];
               w_wdata_nxt      = i_req_wdata;
               w_resp_rdata_nxt = '0;
               w_resp_err_nxt   = 1'b0;
               if (w_misalign) begin
                  w_resp_valid_nxt = 1'b1;
                  w_resp_err_nxt   = 1'b1;
                  w_state_nxt      = StResp;
               end else if (i_req_we && i_req_bhw[1]) begin
                  w_wbuf_nxt  = i_req_wdata;
                  w_state_nxt = StWr;
               end else begin
                  w_state_nxt = StRd;
               end
            end
         end
         StRd: begin
            w_state_nxt = StMrg;
         end
         StMrg: begin
            if (r_we) begin
               w_wbuf_nxt  = w_merged;
               w_state_nxt = StWr;
            end else begin
               w_resp_rdata_nxt = w_load_data;
               w_resp_valid_nxt = 1'b1;
               w_state_nxt      = StResp;
            end
         end
         StWr: begin
            w_resp_valid_nxt = 1'b1;
            w_state_nxt      = StResp;
         end
         StResp: begin
            w_resp_rdata_nxt = '0;
            w_resp_err_nxt   = 1'b0;
            w_state_nxt      = StIdle;
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_we         <= 1'b0;
         r_bhw        <= 2'd0;
         r_sign       <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_wbuf       <= '0;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= '0;
         r_resp_err   <= 1'b0;
      end else begin
         r_we         <= w_we_nxt;
         r_bhw        <= w_bhw_nxt;
         r_sign       <= w_sign_nxt;
         r_addr       <= w_addr_nxt;
         r_wdata      <= w_wdata_nxt;
         r_wbuf       <= w_wbuf_nxt;
         r_resp_valid <= w_resp_valid_nxt;
         r_resp_rdata <= w_resp_rdata_nxt;
         r_resp_err   <= w_resp_err_nxt;
      end
   end

   assign o_req_ready  = (r_state == StIdle);
   assign o_mem_re     = (r_state == StRd);
   assign o_mem_we     = (r_state == StWr);
   assign o_mem_addr   = r_addr[AddrKeep-1:2];
   assign o_mem_wdata  = r_wbuf;
   assign o_resp_valid = r_resp_valid;
   assign o_resp_rdata = r_resp_rdata;
   assign o_resp_err   = r_resp_err;

endmodule

// File: tb/tb_lsu_mem_sequencer.sv
// Directed bench for lsu_mem_sequencer with a behavioural single-port memory.
module tb_lsu_mem_sequencer;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_bhw;
   logic        req_sign;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_re;
   logic        mem_we;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   logic [31:0] mem [1024];

   int n_pass;
   int n_total;
   int n_fail;

   lsu_mem_sequencer #(
      .WIDTH  (32),
      .MEM_AW (10)
   ) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_req_valid  (req_valid),
      .o_req_ready  (req_ready),
      .i_req_we     (req_we),
      .i_req_bhw    (req_bhw),
      .i_req_sign   (req_sign),
      .i_req_addr   (req_addr),
      .i_req_wdata  (req_wdata),
      .o_resp_valid (resp_valid),
      .o_resp_rdata (resp_rdata),
      .o_resp_err   (resp_err),
      .o_mem_re     (mem_re),
      .o_mem_we     (mem_we),
      .o_mem_addr   (mem_addr),
      .o_mem_wdata  (mem_wdata),
      .i_mem_rdata  (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue one request and watch cycles 1..6 after the accept edge.
   // Expected cycle numbers of 0 mean the event must not occur.
   task automatic do_req(input string tag, input logic we, input logic [1:0] bhw,
                         input logic sign, input logic [31:0] addr, input logic [31:0] wdata,
                         input int exp_resp, input int exp_re, input int exp_we,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input logic [31:0] exp_wdata);
      int re_cyc, we_cyc, rv_cyc, re_cnt, we_cnt, rv_cnt, overlap;
      logic [31:0] got_rdata, got_wdata;
      logic [9:0]  got_addr;
      logic        got_err;
      re_cyc = 0; we_cyc = 0; rv_cyc = 0; re_cnt = 0; we_cnt = 0; rv_cnt = 0; overlap = 0;
      got_rdata = 32'h0; got_wdata = 32'h0; got_addr = 10'h0; got_err = 1'b0;
      @(negedge clk);
      chk({tag, " ready_before"}, {31'b0, req_ready}, 32'd1);
      req_we = we; req_bhw = bhw; req_sign = sign; req_addr = addr; req_wdata = wdata;
      req_valid = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (c == 1) begin
            req_valid = 1'b0;
            chk({tag, " ready_busy"}, {31'b0, req_ready}, 32'd0);
         end
         if (mem_re && mem_we) overlap++;
         if (mem_re) begin
            re_cnt++;
            if (re_cyc == 0) begin re_cyc = c; got_addr = mem_addr; end
         end
         if (mem_we) begin
            we_cnt++;
            if (we_cyc == 0) begin we_cyc = c; got_wdata = mem_wdata; got_addr = mem_addr; end
         end
         if (resp_valid) begin
            rv_cnt++;
            if (rv_cyc == 0) begin rv_cyc = c; got_rdata = resp_rdata; got_err = resp_err; end
         end
      end
      chk({tag, " resp_cycle"}, rv_cyc, exp_resp);
      chk({tag, " resp_count"}, rv_cnt, 32'd1);
      chk({tag, " re_cycle"}, re_cyc, exp_re);
      chk({tag, " re_count"}, re_cnt, (exp_re != 0) ? 32'd1 : 32'd0);
      chk({tag, " we_cycle"}, we_cyc, exp_we);
      chk({tag, " we_count"}, we_cnt, (exp_we != 0) ? 32'd1 : 32'd0);
      chk({tag, " re_we_overlap"}, overlap, 32'd0);
      chk({tag, " rdata"}, got_rdata, exp_rdata);
      chk({tag, " err"}, {31'b0, got_err}, {31'b0, exp_err});
      if (exp_we != 0) chk({tag, " wdata"}, got_wdata, exp_wdata);
      if (exp_re != 0 || exp_we != 0) chk({tag, " mem_addr"}, {22'b0, got_addr}, {22'b0, addr[11:2]});
   endtask

   initial begin
      int we_seen, rv_seen;
      n_pass = 0; n_total = 0; n_fail = 0;
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      mem[10'h40] = 32'h8899AABB;
      mem_rdata = 32'h0;
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_bhw = 2'd0; req_sign = 1'b0;
      req_addr = 32'h0; req_wdata = 32'h0;
      repeat (3) @(negedge clk);
      chk("rst ready", {31'b0, req_ready}, 32'd1);
      chk("rst resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("rst resp_err", {31'b0, resp_err}, 32'd0);
      chk("rst resp_rdata", resp_rdata, 32'h0);
      chk("rst mem_re", {31'b0, mem_re}, 32'd0);
      chk("rst mem_we", {31'b0, mem_we}, 32'd0);
      chk("rst mem_wdata", mem_wdata, 32'h0);
      chk("rst mem_addr", {22'b0, mem_addr}, 32'h0);
      rst_n = 1'b1;

      //        tag     we    bhw  sg   addr        wdata       rsp re we rdata        err  wdata
      do_req("LB",   1'b0, 2'd0, 1'b1, 32'h101, 32'h0,        3, 1, 0, 32'hFFFFFFAA, 1'b0, 32'h0);
      do_req("LBU",  1'b0, 2'd0, 1'b0, 32'h101, 32'h0,        3, 1, 0, 32'h000000AA, 1'b0, 32'h0);
      do_req("LB0",  1'b0, 2'd0, 1'b1, 32'h100, 32'h0,        3, 1, 0, 32'hFFFFFFBB, 1'b0, 32'h0);
      do_req("LH",   1'b0, 2'd1, 1'b1, 32'h102, 32'h0,        3, 1, 0, 32'hFFFF8899, 1'b0, 32'h0);
      do_req("LHU",  1'b0, 2'd1, 1'b0, 32'h102, 32'h0,        3, 1, 0, 32'h00008899, 1'b0, 32'h0);
      do_req("LHU0", 1'b0, 2'd1, 1'b0, 32'h100, 32'h0,        3, 1, 0, 32'h0000AABB, 1'b0, 32'h0);
      do_req("LW",   1'b0, 2'd2, 1'b1, 32'h100, 32'h0,        3, 1, 0, 32'h8899AABB, 1'b0, 32'h0);
      do_req("SB",   1'b1, 2'd0, 1'b0, 32'h102, 32'h12345677, 4, 1, 3, 32'h0, 1'b0, 32'h8877AABB);
      do_req("SH",   1'b1, 2'd1, 1'b0, 32'h102, 32'h0000BEEF, 4, 1, 3, 32'h0, 1'b0, 32'hBEEFAABB);
      do_req("SW",   1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 2, 0, 1, 32'h0, 1'b0, 32'hDEADBEEF);
      do_req("LHmis",1'b0, 2'd1, 1'b1, 32'h101, 32'h0,        1, 0, 0, 32'h0, 1'b1, 32'h0);
      do_req("SWmis",1'b1, 2'd2, 1'b0, 32'h102, 32'hCAFEF00D, 1, 0, 0, 32'h0, 1'b1, 32'h0);
      do_req("B3mis",1'b0, 2'd3, 1'b0, 32'h101, 32'h0,        1, 0, 0, 32'h0, 1'b1, 32'h0);
      do_req("LWok", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0,        3, 1, 0, 32'hDEADBEEF, 1'b0, 32'h0);

      // Abort a sub-word store with reset asserted while it is in the read cycle.
      we_seen = 0; rv_seen = 0;
      @(negedge clk);
      req_we = 1'b1; req_bhw = 2'd0; req_sign = 1'b0; req_addr = 32'h103; req_wdata = 32'h000000AB;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      chk("abort mem_re", {31'b0, mem_re}, 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("abort ready_after", {31'b0, req_ready}, 32'd1);
      for (int c = 0; c < 6; c++) begin
         if (mem_we) we_seen++;
         if (resp_valid) rv_seen++;
         @(negedge clk);
      end
      chk("abort no_we", we_seen, 32'd0);
      chk("abort no_resp", rv_seen, 32'd0);

      do_req("SBpost", 1'b1, 2'd0, 1'b0, 32'h103, 32'h00000055, 4, 1, 3, 32'h0, 1'b0, 32'h55ADBEEF);
      do_req("LBpost", 1'b0, 2'd0, 1'b1, 32'h103, 32'h0,        3, 1, 0, 32'h00000055, 1'b0, 32'h0);
      do_req("LWpost", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0,        3, 1, 0, 32'h55ADBEEF, 1'b0, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
